// File: rtl/pulse_stretch_multi.sv
// Multi-channel pulse stretcher: rising edges on pls become len-cycle pulses on lg_pls, with busy/done status.
// Define PULSE_STRETCH_SYNC_EN to pass each pls bit through a 2-flop synchroniser before edge detection.
module pulse_stretch_multi #(
    parameter int CH = 4,
    parameter int CW = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] pls,
    input  logic [CW-1:0] len,
    input  logic          retrig,
    output logic [CH-1:0] lg_pls,
    output logic [CH-1:0] busy,
    output logic [CH-1:0] done
);

    typedef enum logic {
        IDLE = 1'b0,
        HIGH = 1'b1
    } state_t;

    // Counter load value is len_eff-1; a zero length behaves as a one-cycle pulse.
    logic [CW-1:0] len_load;
    assign len_load = (len == '0) ? '0 : (len - CW'(1));

    logic [CH-1:0] pls_in;

`ifdef PULSE_STRETCH_SYNC_EN
    logic [CH-1:0] sync1_reg;
    logic [CH-1:0] sync2_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= pls;
            sync2_reg <= sync1_reg;
        end
    end

    assign pls_in = sync2_reg;
`else
    assign pls_in = pls;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            state_t        state_reg;
            logic [CW-1:0] cnt_reg;
            logic          pls_q_reg;
            logic          lg_reg;
            logic          done_reg;
            logic          edge_det;

            // History resets to 0, so a level already high after reset counts as one edge.
            assign edge_det = pls_in[gi] & ~pls_q_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    pls_q_reg <= 1'b0;
                    lg_reg    <= 1'b0;
                    done_reg  <= 1'b0;
                end else begin
                    pls_q_reg <= pls_in[gi];
                    done_reg  <= 1'b0;
                    case (state_reg)
                        IDLE: begin
                            if (edge_det) begin
                                cnt_reg   <= len_load;
                                state_reg <= HIGH;
                                lg_reg    <= 1'b1;
                            end
                        end
                        HIGH: begin
                            // Reload wins over expiry, so a retrigger in the last cycle leaves no gap.
                            if (edge_det && retrig) begin
                                cnt_reg <= len_load;
                            end else if (cnt_reg == '0) begin
                                state_reg <= IDLE;
                                lg_reg    <= 1'b0;
                                done_reg  <= 1'b1;
                            end else begin
                                cnt_reg <= cnt_reg - CW'(1);
                            end
                        end
                        default: begin
                            state_reg <= IDLE;
                            lg_reg    <= 1'b0;
                        end
                    endcase
                end
            end

            assign lg_pls[gi] = lg_reg;
            assign busy[gi]   = lg_reg;
            assign done[gi]   = done_reg;
        end
    endgenerate

endmodule

// File: tb/tb_pulse_stretch_multi.sv
// Self-checking bench for pulse_stretch_multi: end-time reference model, per-cycle compare, directed and random stimulus.
`timescale 1ns/1ps
module tb_pulse_stretch_multi;
    localparam int CH   = 4;
    localparam int CW   = 17;
    localparam int NPAT = 40;
`ifdef PULSE_STRETCH_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] pls;
    logic [CW-1:0] len;
    logic          retrig;
    logic [CH-1:0] lg_pls;
    logic [CH-1:0] busy;
    logic [CH-1:0] done;

    always #5 clk = ~clk;

    pulse_stretch_multi #(.CH(CH), .CW(CW)) dut (
        .clk    (clk),
        .rst    (rst),
        .pls    (pls),
        .len    (len),
        .retrig (retrig),
        .lg_pls (lg_pls),
        .busy   (busy),
        .done   (done)
    );

    int checks = 0;
    int errors = 0;

    // Reference: each channel remembers the cycle number of its last high cycle.
    int            cyc = 0;
    int            end_t [CH];
    bit            prev_in [CH];
    bit            sd1 [CH];
    bit            sd2 [CH];
    logic [CH-1:0] exp_lg = '0;
    logic [CH-1:0] exp_done = '0;

    initial begin
        for (int c = 0; c < CH; c++) begin
            end_t[c] = -1; prev_in[c] = 0; sd1[c] = 0; sd2[c] = 0;
        end
    end

    always @(posedge clk) begin
        int leff;
        bit was_high;
        bit s;
        bit e;
        cyc++;
        leff = (len == 0) ? 1 : int'(len);
        for (int c = 0; c < CH; c++) begin
            was_high = exp_lg[c];
            if (rst) begin
                end_t[c] = -1; prev_in[c] = 0; sd1[c] = 0; sd2[c] = 0;
                exp_lg[c] = 1'b0; exp_done[c] = 1'b0;
            end else begin
`ifdef PULSE_STRETCH_SYNC_EN
                s = sd2[c];
                sd2[c] = sd1[c];
                sd1[c] = pls[c];
`else
                s = pls[c];
`endif
                e = s && !prev_in[c];
                prev_in[c] = s;
                if (e && (!was_high || retrig))
                    end_t[c] = cyc + leff - 1;
                exp_lg[c]   = (cyc <= end_t[c]);
                exp_done[c] = was_high && !exp_lg[c];
            end
        end
    end

    bit chk_en = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (lg_pls !== exp_lg) begin
                errors++;
                $display("FAIL lg_pls cycle %0d: got %b expected %b", cyc, lg_pls, exp_lg);
            end
            checks++;
            if (busy !== exp_lg) begin
                errors++;
                $display("FAIL busy cycle %0d: got %b expected %b", cyc, busy, exp_lg);
            end
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL done cycle %0d: got %b expected %b", cyc, done, exp_done);
            end
        end
    end

    task automatic expect_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end else begin
            $display("ok   %s = %0d", name, got);
        end
    endtask

    // Directed pattern tables: per offset, the pls/len/rst values to drive.
    logic [CH-1:0] pat [NPAT];
    logic [CW-1:0] len_at [NPAT];
    logic          rst_at [NPAT];
    int            hi_cnt [CH];
    int            dn_cnt [CH];
    int            first_hi [CH];

    task automatic clear_pattern(input int l, input logic rt);
        for (int i = 0; i < NPAT; i++) begin
            pat[i] = '0; len_at[i] = CW'(l); rst_at[i] = 1'b0;
        end
        retrig = rt;
    endtask

    task automatic run_pattern();
        for (int c = 0; c < CH; c++) begin
            hi_cnt[c] = 0; dn_cnt[c] = 0; first_hi[c] = -1;
        end
        for (int i = 0; i < NPAT; i++) begin
            @(posedge clk); #1;
            pls = pat[i]; len = len_at[i]; rst = rst_at[i];
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                if (lg_pls[c]) begin
                    hi_cnt[c]++;
                    if (first_hi[c] < 0) first_hi[c] = i;
                end
                if (done[c]) dn_cnt[c]++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; pls = '0; len = '0; retrig = 1'b0;
        @(posedge clk); #1;
        chk_en = 1;
        @(negedge clk);
        expect_int("reset lg_pls", int'(lg_pls), 0);
        expect_int("reset busy", int'(busy), 0);
        expect_int("reset done", int'(done), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        clear_pattern(5, 1'b0);
        pat[0] = 4'b0001;
        run_pattern();
        expect_int("len5 latency", first_hi[0], LAT);
        expect_int("len5 high", hi_cnt[0], 5);
        expect_int("len5 done", dn_cnt[0], 1);
        expect_int("len5 others", hi_cnt[1] + hi_cnt[2] + hi_cnt[3], 0);

        clear_pattern(0, 1'b0);
        pat[0] = 4'b0010;
        run_pattern();
        expect_int("len0 high", hi_cnt[1], 1);
        expect_int("len0 done", dn_cnt[1], 1);

        clear_pattern(3, 1'b0);
        for (int i = 0; i < 20; i++) pat[i] = 4'b0100;
        run_pattern();
        expect_int("held high", hi_cnt[2], 3);
        expect_int("held done", dn_cnt[2], 1);

        clear_pattern(8, 1'b1);
        pat[0] = 4'b0001; pat[6] = 4'b0001;
        run_pattern();
        expect_int("retrig high", hi_cnt[0], 14);
        expect_int("retrig done", dn_cnt[0], 1);

        clear_pattern(8, 1'b0);
        pat[0] = 4'b0001; pat[6] = 4'b0001;
        run_pattern();
        expect_int("noretrig high", hi_cnt[0], 8);
        expect_int("noretrig done", dn_cnt[0], 1);

        clear_pattern(4, 1'b0);
        pat[0] = 4'b0001; pat[5] = 4'b0001;
        run_pattern();
        expect_int("rearm high", hi_cnt[0], 8);
        expect_int("rearm done", dn_cnt[0], 2);

        clear_pattern(4, 1'b1);
        pat[0] = 4'b0001; pat[4] = 4'b0001;
        run_pattern();
        expect_int("lastcyc retrig high", hi_cnt[0], 8);
        expect_int("lastcyc retrig done", dn_cnt[0], 1);

        clear_pattern(3, 1'b0);
        pat[0] = 4'b0001; pat[4] = 4'b0010; pat[8] = 4'b0100; pat[12] = 4'b1000;
        for (int i = 4; i < NPAT; i++) len_at[i] = (i < 8) ? CW'(5) : (i < 12) ? CW'(7) : CW'(9);
        run_pattern();
        for (int c = 0; c < CH; c++) expect_int($sformatf("stagger ch%0d high", c), hi_cnt[c], 3 + 2 * c);

        clear_pattern(10, 1'b0);
        pat[0] = 4'b0001; rst_at[5] = 1'b1;
        run_pattern();
        expect_int("midreset high", hi_cnt[0], 6 - LAT);
        expect_int("midreset done", dn_cnt[0], 0);

        clear_pattern(4, 1'b0);
        for (int i = 0; i < 30; i++) pat[i] = 4'b1000;
        rst_at[0] = 1'b1; rst_at[1] = 1'b1; rst_at[2] = 1'b1;
        run_pattern();
        expect_int("held across reset high", hi_cnt[3], 4);
        expect_int("held across reset done", dn_cnt[3], 1);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            for (int c = 0; c < CH; c++) pls[c] = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 19) == 0)
                len = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(20, 40)) : CW'($urandom_range(0, 12));
            if ($urandom_range(0, 49) == 0) retrig = ~retrig;
            rst = ($urandom_range(0, 299) == 0);
        end

        @(posedge clk); #1;
        rst = 1'b0; pls = '0;
        repeat (60) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
